// File: rtl/tl_cntr_param_if.sv
// ---------------------------------------------------------------------------
// tl_cntr_param_if
//  Bundle of sensor inputs and lamp/status outputs of the traffic-light
//  controller.
//  Signals:
//   t         N_DIR    traffic-present sensor per direction (level)
//   left_req  N_DIR    left-turn request per direction (pulse or level)
//   emerg     1        emergency preempt (level)
//   lights    2*N_DIR  lamp code per direction, [2d+1:2d]
//   cur_dir   2        direction owning right-of-way
//   phase     3        0 GREEN, 1 YEL1, 2 LEFT, 3 YEL2, 4 ALL_RED, 5 EMERG
//   left_pend N_DIR    latched left-turn requests
//  Modports: master drives sensors (environment), slave is the controller.
// ---------------------------------------------------------------------------
interface tl_cntr_param_if #(
  parameter int N_DIR = 2
);
  logic [N_DIR-1:0]   t;
  logic [N_DIR-1:0]   left_req;
  logic               emerg;
  logic [2*N_DIR-1:0] lights;
  logic [1:0]         cur_dir;
  logic [2:0]         phase;
  logic [N_DIR-1:0]   left_pend;

  modport master (
    output t, left_req, emerg,
    input  lights, cur_dir, phase, left_pend
  );

  modport slave (
    input  t, left_req, emerg,
    output lights, cur_dir, phase, left_pend
  );
endinterface

// File: rtl/tl_cntr_param.sv
// ---------------------------------------------------------------------------
// tl_cntr_param
//  N-direction round-robin traffic-light controller with protected left-turn
//  phases, sensor-extended green, skipping of idle directions, rest-in-green
//  and emergency preemption.
//  Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    tl_cntr_param_if.slave: t, left_req, emerg in;
//          lights, cur_dir, phase, left_pend out (all registered)
// ---------------------------------------------------------------------------
module tl_cntr_param #(
  parameter int N_DIR   = 2,
  parameter int G_MIN   = 8,
  parameter int G_MAX   = 32,
  parameter int Y_TIME  = 3,
  parameter int L_TIME  = 5,
  parameter int AR_TIME = 2
) (
  input  logic              clk,
  input  logic              reset,
  tl_cntr_param_if.slave    bus
);

  localparam int M1   = (G_MAX > L_TIME) ? G_MAX : L_TIME;
  localparam int M2   = (Y_TIME > AR_TIME) ? Y_TIME : AR_TIME;
  localparam int TMAX = (M1 > M2) ? M1 : M2;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [2*N_DIR-1:0] LIGHTS_RST = {{(N_DIR-1){2'b11}}, 2'b00};

  typedef enum logic [2:0] {
    PH_GREEN  = 3'd0,
    PH_YEL1   = 3'd1,
    PH_LEFT   = 3'd2,
    PH_YEL2   = 3'd3,
    PH_ALLRED = 3'd4,
    PH_EMERG  = 3'd5
  } phase_e;

  phase_e             phase_q, phase_d;
  logic [1:0]         cur_q, cur_d;
  logic [TW-1:0]      elapsed_q, elapsed_d;
  logic [N_DIR-1:0]   left_pend_q, left_pend_d;
  logic [2*N_DIR-1:0] lights_q, lights_d;

  logic [N_DIR-1:0]   own;       // one-hot of the current owner
  logic [N_DIR-1:0]   dem;       // per-direction demand
  logic [3:0]         dem4;      // demand widened so a 2-bit index is exact
  logic               other_dem;
  logic               own_t;
  logic               own_left;
  logic [1:0]         next_dir;
  logic [1:0]         owner_code;

  assign dem       = bus.t | left_pend_q;
  assign dem4      = 4'(dem);
  assign other_dem = |(dem & ~own);
  assign own_t     = |(bus.t & own);
  assign own_left  = |(left_pend_q & own);

  generate
    for (genvar gi = 0; gi < N_DIR; gi++) begin : g_dir
      assign own[gi] = (cur_q == 2'(gi));
      // Lamp codes follow the next-state owner/phase so outputs stay registered.
      assign lights_d[2*gi +: 2] = (cur_d == 2'(gi)) ? owner_code : 2'b11;
    end
  endgenerate

  // Next demanded direction, searched cyclically from cur+1. The owner itself
  // is the last candidate; with no demand anywhere, advance by one.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    found    = 1'b0;
    idx      = 2'd0;
    next_dir = (cur_q == 2'(N_DIR - 1)) ? 2'd0 : cur_q + 2'd1;
    for (int k = 1; k <= N_DIR; k++) begin
      idx = 2'((int'(cur_q) + k) % N_DIR);
      if (!found && dem4[idx]) begin
        next_dir = idx;
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    phase_d = phase_q;
    cur_d   = cur_q;
    if (bus.emerg) begin
      phase_d = PH_EMERG;
    end else begin
      unique case (phase_q)
        PH_GREEN: begin
          if ((elapsed_q >= TW'(G_MIN)) &&
              (!own_t || (elapsed_q == TW'(G_MAX))) &&
              (other_dem || own_left))
            phase_d = PH_YEL1;
        end
        PH_YEL1: begin
          if (elapsed_q == TW'(Y_TIME))
            phase_d = own_left ? PH_LEFT : PH_ALLRED;
        end
        PH_LEFT: begin
          if (elapsed_q == TW'(L_TIME))
            phase_d = PH_YEL2;
        end
        PH_YEL2: begin
          if (elapsed_q == TW'(Y_TIME))
            phase_d = PH_ALLRED;
        end
        PH_ALLRED: begin
          if (elapsed_q == TW'(AR_TIME)) begin
            phase_d = PH_GREEN;
            cur_d   = next_dir;
          end
        end
        PH_EMERG: phase_d = PH_ALLRED;
        default:  phase_d = PH_ALLRED;
      endcase
    end
  end

  // Timer restarts at 1 on every phase change. Green rests at G_MAX; other
  // phases leave before reaching TMAX, EMERG simply saturates.
  always_comb begin
    if (phase_d != phase_q)
      elapsed_d = TW'(1);
    else if ((phase_q == PH_GREEN) && (elapsed_q >= TW'(G_MAX)))
      elapsed_d = elapsed_q;
    else if (elapsed_q == TW'(TMAX))
      elapsed_d = elapsed_q;
    else
      elapsed_d = elapsed_q + TW'(1);
  end

  // Left latch: entering LEFT clears the owner's bit, even if a new request
  // arrives on that same edge.
  always_comb begin
    left_pend_d = left_pend_q | bus.left_req;
    if ((phase_q == PH_YEL1) && (phase_d == PH_LEFT))
      left_pend_d = left_pend_d & ~own;
  end

  always_comb begin
    unique case (phase_d)
      PH_GREEN:         owner_code = 2'b00;
      PH_YEL1, PH_YEL2: owner_code = 2'b01;
      PH_LEFT:          owner_code = 2'b10;
      default:          owner_code = 2'b11;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q     <= PH_GREEN;
      cur_q       <= 2'd0;
      elapsed_q   <= TW'(1);
      left_pend_q <= '0;
      lights_q    <= LIGHTS_RST;
    end else begin
      phase_q     <= phase_d;
      cur_q       <= cur_d;
      elapsed_q   <= elapsed_d;
      left_pend_q <= left_pend_d;
      lights_q    <= lights_d;
    end
  end

  assign bus.lights    = lights_q;
  assign bus.cur_dir   = cur_q;
  assign bus.phase     = phase_q;
  assign bus.left_pend = left_pend_q;

endmodule
